// File: rtl/fpu_arb_pkg.sv
// Shared types and helpers for the FPU bank arbiter.
// The owner index is at least one bit wide, even when there is only one requester.
package fpu_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT,
        DONE
    } arb_state_e;

    localparam int OP_NOP = 0;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fpu_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible index at or above ptr, wrapping upward.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   index
);

    logic [NUM_REQ-1:0] rotated;

    always_comb begin
        // After this rotation, bit k of rotated stands for requester (ptr + k) mod NUM_REQ.
        rotated = NUM_REQ'({eligible, eligible} >> ptr);
        found   = |rotated;
        index   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                index = SEL_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin owner of a single FPU bank: it latches the winner's op, drives the FPU handshake
// and aborts an operation that does not complete in time.
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int OP_W        = 8,
    parameter int TIMEOUT_CYC = 4096,
    parameter int SEL_W       = sel_width(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*OP_W-1:0] req_op,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [SEL_W-1:0]        sel,
    output logic                    sel_valid,
    output logic [OP_W-1:0]         fpu_op,
    input  logic                    fpu_avail,
    input  logic                    fpu_done,
    output logic                    timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [OP_W-1:0] NOP = OP_W'(OP_NOP);

    arb_state_e          state, next_state;
    logic [SEL_W-1:0]    owner, next_owner;
    logic [SEL_W-1:0]    rr_ptr, next_ptr;
    logic [OP_W-1:0]     op_q, next_op;
    logic [WD_W-1:0]     watchdog;
    logic                next_timeout;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  next_onehot;
    logic                pick_found;
    logic [SEL_W-1:0]    pick_idx;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req[i] && (req_op[i*OP_W +: OP_W] != NOP);
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .found    (pick_found),
        .index    (pick_idx)
    );

    always_comb begin
        next_state   = state;
        next_owner   = owner;
        next_op      = op_q;
        next_ptr     = rr_ptr;
        next_timeout = timeout_err;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    next_owner = pick_idx;
                    next_op    = req_op[int'(pick_idx)*OP_W +: OP_W];
                    next_state = SETUP;
                end
            end
            SETUP: next_state = ISSUE;
            ISSUE: begin
                if (fpu_avail) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                // A completion arriving on the expiry cycle is honoured, not flagged.
                if (fpu_done) begin
                    next_state = DONE;
                end else if (watchdog == WD_W'(TIMEOUT_CYC - 1)) begin
                    next_timeout = 1'b1;
                    next_state   = DONE;
                end
            end
            DONE: begin
                next_ptr   = (owner == SEL_W'(NUM_REQ - 1)) ? '0 : owner + SEL_W'(1);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        next_onehot = NUM_REQ'(1) << next_owner;
    end

    // Outputs are registered from the next state, so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state       <= IDLE;
            owner       <= '0;
            op_q        <= NOP;
            rr_ptr      <= '0;
            watchdog    <= '0;
            timeout_err <= 1'b0;
            grant       <= '0;
            req_done    <= '0;
            sel         <= '0;
            sel_valid   <= 1'b0;
            fpu_op      <= NOP;
        end else begin
            state       <= next_state;
            owner       <= next_owner;
            op_q        <= next_op;
            rr_ptr      <= next_ptr;
            timeout_err <= next_timeout;
            watchdog    <= (state == WAIT && next_state == WAIT) ? watchdog + WD_W'(1) : '0;
            grant       <= (next_state != IDLE) ? next_onehot : '0;
            req_done    <= (next_state == DONE) ? next_onehot : '0;
            sel         <= next_owner;
            sel_valid   <= (next_state != IDLE);
            fpu_op      <= (next_state == ISSUE) ? next_op : NOP;
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: a transaction-level ownership model checked every cycle, plus
// directed scenarios with hand-computed cycle expectations.
module tb_fpu_arbiter;

    localparam int N  = 4;
    localparam int OW = 8;
    localparam int TO = 16;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_l = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*OW-1:0] req_op = '0;
    logic [N-1:0]    grant, req_done;
    logic [SW-1:0]   sel;
    logic            sel_valid, timeout_err;
    logic [OW-1:0]   fpu_op;
    logic            fpu_avail = 1'b1;
    logic            fpu_done;
    logic            done_r = 1'b0, spur_done = 1'b0;
    int              done_lat = 1;
    int              done_cnt = 0;
    int              n_checks = 0, n_fail = 0;
    bit              cmp_en = 0;

    assign fpu_done = done_r | spur_done;

    always #5 clk = ~clk;

    fpu_arbiter #(
        .NUM_REQ     (N),
        .OP_W        (OW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .req         (req),
        .req_op      (req_op),
        .grant       (grant),
        .req_done    (req_done),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .fpu_op      (fpu_op),
        .fpu_avail   (fpu_avail),
        .fpu_done    (fpu_done),
        .timeout_err (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FPU stand-in: completes done_lat cycles after accepting an op (0 = never completes).
    always @(negedge clk) begin
        #2;
        done_r = 1'b0;
        if (!rst_l) begin
            done_cnt = 0;
        end else begin
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) done_r = 1'b1;
            end
            if (fpu_op != 0 && fpu_avail && done_lat > 0) done_cnt = done_lat;
        end
    end

    // Ownership model: one record per granted transaction, walked through setup/issue/wait/finish.
    bit m_busy, m_setup, m_accepted, m_ending, m_terr;
    int m_owner, m_op, m_ptr, m_wcnt;

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req[idx] && req_op[idx*OW +: OW] != 0) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            m_busy <= 0; m_setup <= 0; m_accepted <= 0; m_ending <= 0; m_terr <= 0;
            m_owner <= 0; m_op <= 0; m_ptr <= 0; m_wcnt <= 0;
        end else if (!m_busy) begin
            if (model_pick() >= 0) begin
                m_busy     <= 1;
                m_owner    <= model_pick();
                m_op       <= int'(req_op[model_pick()*OW +: OW]);
                m_setup    <= 1;
                m_accepted <= 0;
                m_ending   <= 0;
                m_wcnt     <= 0;
            end
        end else if (m_ending) begin
            m_busy   <= 0;
            m_ending <= 0;
            m_ptr    <= (m_owner + 1) % N;
        end else if (m_setup) begin
            m_setup <= 0;
        end else if (!m_accepted) begin
            if (fpu_avail) m_accepted <= 1;
        end else if (fpu_done) begin
            m_ending <= 1;
        end else if (m_wcnt == TO - 1) begin
            m_terr   <= 1;
            m_ending <= 1;
        end else begin
            m_wcnt <= m_wcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_l && cmp_en) begin
            logic [N-1:0]  e_grant, e_done;
            logic [OW-1:0] e_op;
            e_grant = m_busy ? N'(1) << m_owner : '0;
            e_done  = m_ending ? N'(1) << m_owner : '0;
            e_op    = (m_busy && !m_setup && !m_accepted) ? OW'(m_op) : '0;
            check("grant", grant, e_grant);
            check("req_done", req_done, e_done);
            check("sel_valid", sel_valid, m_busy);
            check("fpu_op", fpu_op, e_op);
            check("timeout_err", timeout_err, m_terr);
            check("grant_onehot", ($countones(grant) <= 1), 1);
            if (m_busy) check("sel", sel, m_owner);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_l = 1'b0;
        req = '0; req_op = '0; fpu_avail = 1'b1; spur_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [OW-1:0] op);
        req[i] = 1'b1;
        req_op[i*OW +: OW] = op;
    endtask

    function automatic int grant_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    initial begin
        int got, held;
        logic [N-1:0] prev;
        logic [7:0] exp_q[$];
        logic [7:0] op_q[$];

        // Reset values
        @(negedge clk);
        rst_l = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_req_done", req_done, 0);
        check("rst_sel", sel, 0);
        check("rst_sel_valid", sel_valid, 0);
        check("rst_fpu_op", fpu_op, 0);
        check("rst_timeout", timeout_err, 0);
        @(negedge clk);
        rst_l = 1'b1;
        cmp_en = 1;

        // Single requester, FPU done 3 cycles after accept
        do_reset();
        done_lat = 3;
        @(negedge clk); set_req(2, 8'h05);
        @(negedge clk);
        check("t1_grant", grant, 4'b0100);
        check("t1_sel", sel, 2);
        check("t1_op_setup", fpu_op, 0);
        req = '0;
        @(negedge clk); check("t1_op_issue", fpu_op, 8'h05);
        @(negedge clk); check("t1_op_wait", fpu_op, 0);
        repeat (3) @(negedge clk);
        check("t1_done", req_done, 4'b0100);
        check("t1_grant_in_done", grant, 4'b0100);
        @(negedge clk);
        check("t1_release", grant, 0);
        check("t1_done_pulse", req_done, 0);

        // All four requesting continuously
        do_reset();
        done_lat = 1;
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, 8'(i + 1));
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        op_q  = '{8'h01, 8'h02, 8'h03, 8'h04};
        got = 0;
        prev = '0;
        for (int c = 0; c < 80 && got < 5; c++) begin
            @(negedge clk);
            if (grant != 0 && prev == 0) begin
                check("t2_order", grant_idx(grant), exp_q.pop_front());
                got++;
            end
            if (fpu_op != 0 && op_q.size() > 0) check("t2_op", fpu_op, op_q.pop_front());
            prev = grant;
        end
        check("t2_grant_count", got, 5);

        // fpu_avail low for 5 ISSUE cycles
        do_reset();
        done_lat = 1;
        fpu_avail = 1'b0;
        @(negedge clk); set_req(0, 8'h05);
        @(negedge clk); req = '0;
        held = 0;
        for (int c = 2; c < 12; c++) begin
            @(negedge clk);
            if (fpu_op == 8'h05) held++;
            if (c <= 9) check("t3_grant", grant, 4'b0001);
            if (c == 7) fpu_avail = 1'b1;
        end
        check("t3_op_held", held, 6);

        // Watchdog expiry with TIMEOUT_CYC = 16
        do_reset();
        done_lat = 0;
        @(negedge clk); set_req(1, 8'h07); set_req(2, 8'h09);
        @(negedge clk);
        check("t4_grant1", grant, 4'b0010);
        req[1] = 1'b0;
        repeat (17) @(negedge clk);
        check("t4_terr_before", timeout_err, 0);
        check("t4_no_done_yet", req_done, 0);
        @(negedge clk);
        check("t4_terr", timeout_err, 1);
        check("t4_done", req_done, 4'b0010);
        done_lat = 1;
        @(negedge clk); check("t4_idle", grant, 0);
        @(negedge clk); check("t4_next_grant", grant, 4'b0100);
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (req_done == 4'b0100) got = 1;
        end
        check("t4_next_done", got, 1);
        req = '0;
        check("t4_terr_sticky", timeout_err, 1);

        // Asynchronous reset mid-WAIT
        do_reset();
        done_lat = 0;
        @(negedge clk); set_req(1, 8'h11);
        repeat (4) @(negedge clk);
        check("t5_grant_pre", grant, 4'b0010);
        #1 rst_l = 1'b0;
        #1;
        check("t5_grant_async", grant, 0);
        check("t5_op_async", fpu_op, 0);
        check("t5_sel_valid_async", sel_valid, 0);
        check("t5_terr_async", timeout_err, 0);
        set_req(3, 8'h33);
        done_lat = 1;
        @(negedge clk); rst_l = 1'b1;
        @(negedge clk);
        check("t5_first_after_rst", grant, 4'b0010);
        req[1] = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (grant == 4'b1000) got = 1;
        end
        check("t5_req3_granted", got, 1);
        req = '0;

        // Spurious fpu_done in IDLE and a NOP request
        do_reset();
        @(negedge clk);
        set_req(0, 8'h00);
        spur_done = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t6_grant", grant, 0);
            check("t6_req_done", req_done, 0);
            check("t6_terr", timeout_err, 0);
            if (c == 2) spur_done = 1'b0;
        end
        req = '0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
